// File: rtl/amm_mem_checker.sv
// Memory test engine: CSR-configured Avalon-MM burst master that writes a
// per-address pattern over a range, reads it back and counts mismatches.
module amm_mem_checker #(
  parameter int unsigned AMM_ADDR_W  = 28,
  parameter int unsigned AMM_DATA_W  = 128,
  parameter int unsigned AMM_BURST_W = 11
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_i,
  input  logic                    sys_read_i,
  input  logic                    sys_write_i,
  input  logic [3:0]              sys_address_i,
  input  logic [31:0]             sys_writedata_i,
  output logic                    sys_readdatavalid_o,
  output logic [31:0]             sys_readdata_o,
  input  logic                    mem_waitrequest_i,
  input  logic                    mem_readdatavalid_i,
  input  logic [AMM_DATA_W-1:0]   mem_readdata_i,
  output logic [AMM_ADDR_W-1:0]   mem_address_o,
  output logic                    mem_read_o,
  output logic                    mem_write_o,
  output logic [AMM_DATA_W-1:0]   mem_writedata_o,
  output logic [AMM_BURST_W-1:0]  mem_burstcount_o,
  output logic [AMM_DATA_W/8-1:0] mem_byteenable_o
);

  localparam int unsigned Lanes    = AMM_DATA_W / 32;
  localparam logic [31:0] MaxBurst = 32'd1 << (AMM_BURST_W - 1);

  typedef enum logic [2:0] {StIdle, StWr, StRdCmd, StRdData, StDone} state_e;

  state_e state_q, state_d;

  logic [1:0]             mode_q;
  logic [31:0]            start_addr_q, end_addr_q, burst_len_q, pattern_q;
  logic                   done_q, error_q, cfg_err_q;
  logic [31:0]            err_count_q, first_err_addr_q, cycles_q, cur_q;
  logic [AMM_ADDR_W-1:0]  burst_addr_q;
  logic [AMM_BURST_W-1:0] burst_n_q, beats_left_q;
  logic                   rdvalid_q;
  logic [31:0]            rdata_q, csr_rdata;

  logic                   busy, start_req, cfg_bad, wr_beat, rd_accept, rd_beat;
  logic                   burst_last, addr_last, wr_phase_end, read_phase;
  logic [31:0]            setup_addr;
  logic [AMM_BURST_W-1:0] setup_n;
  logic [AMM_DATA_W-1:0]  exp_data;

  function automatic logic [AMM_DATA_W-1:0] lane_data(input logic [31:0] pat,
                                                      input logic [31:0] a);
    return {Lanes{pat ^ a}};
  endfunction

  // Burst length for a burst starting at a: clamped length, cut at the range end.
  function automatic logic [AMM_BURST_W-1:0] calc_n(input logic [31:0] a,
                                                    input logic [31:0] last,
                                                    input logic [31:0] len);
    logic [32:0] rem;
    logic [31:0] eff;
    rem = {1'b0, last} - {1'b0, a} + 33'd1;
    if (len == '0) begin
      eff = 32'd1;
    end else if (len > MaxBurst) begin
      eff = MaxBurst;
    end else begin
      eff = len;
    end
    if (rem < {1'b0, eff}) begin
      return rem[AMM_BURST_W-1:0];
    end
    return eff[AMM_BURST_W-1:0];
  endfunction

  always_comb begin
    busy         = (state_q == StWr) || (state_q == StRdCmd) || (state_q == StRdData);
    start_req    = sys_write_i && (sys_address_i == 4'd0) && sys_writedata_i[0] && !busy;
    cfg_bad      = start_addr_q > end_addr_q;
    wr_beat      = (state_q == StWr) && !mem_waitrequest_i;
    rd_accept    = (state_q == StRdCmd) && !mem_waitrequest_i;
    rd_beat      = (state_q == StRdData) && mem_readdatavalid_i;
    burst_last   = beats_left_q == AMM_BURST_W'(1);
    addr_last    = cur_q == end_addr_q;
    read_phase   = mode_q != 2'd0;
    wr_phase_end = wr_beat && burst_last && addr_last;
    setup_addr   = (start_req || wr_phase_end) ? start_addr_q : cur_q + 32'd1;
    setup_n      = calc_n(setup_addr, end_addr_q, burst_len_q);
    exp_data     = lane_data(pattern_q, cur_q);
  end

  // FSM state register
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_req) begin
          if (cfg_bad) begin
            state_d = StDone;
          end else if (mode_q == 2'd1) begin
            state_d = StRdCmd;
          end else begin
            state_d = StWr;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWr: begin
        if (wr_phase_end) begin
          state_d = read_phase ? StRdCmd : StDone;
        end
      end
      StRdCmd: begin
        if (rd_accept) begin
          state_d = StRdData;
        end
      end
      StRdData: begin
        if (rd_beat && burst_last) begin
          state_d = addr_last ? StDone : StRdCmd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_write_o      = state_q == StWr;
    mem_read_o       = state_q == StRdCmd;
    mem_address_o    = '0;
    mem_burstcount_o = '0;
    mem_writedata_o  = '0;
    mem_byteenable_o = '0;
    if (mem_write_o || mem_read_o) begin
      mem_address_o    = burst_addr_q;
      mem_burstcount_o = burst_n_q;
    end
    if (mem_write_o) begin
      mem_writedata_o  = exp_data;
      mem_byteenable_o = '1;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      mode_q           <= '0;
      start_addr_q     <= '0;
      end_addr_q       <= '0;
      burst_len_q      <= 32'd1;
      pattern_q        <= '0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
      cfg_err_q        <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      cycles_q         <= '0;
      cur_q            <= '0;
      burst_addr_q     <= '0;
      burst_n_q        <= '0;
      beats_left_q     <= '0;
    end else begin
      if (sys_write_i && !busy) begin
        case (sys_address_i)
          4'd1:    mode_q       <= sys_writedata_i[1:0];
          4'd2:    start_addr_q <= sys_writedata_i;
          4'd3:    end_addr_q   <= sys_writedata_i;
          4'd4:    burst_len_q  <= sys_writedata_i;
          4'd5:    pattern_q    <= sys_writedata_i;
          default: ;
        endcase
      end

      if (busy) begin
        cycles_q <= cycles_q + 32'd1;
      end

      if (start_req) begin
        err_count_q      <= '0;
        first_err_addr_q <= '0;
        cycles_q         <= '0;
        done_q           <= 1'b0;
        error_q          <= 1'b0;
        cfg_err_q        <= cfg_bad;
        cur_q            <= setup_addr;
        burst_addr_q     <= setup_addr[AMM_ADDR_W-1:0];
        burst_n_q        <= setup_n;
        beats_left_q     <= setup_n;
      end

      if (wr_beat) begin
        cur_q        <= cur_q + 32'd1;
        beats_left_q <= beats_left_q - AMM_BURST_W'(1);
        // Next burst (or restart at START_ADDR for the read phase) with no idle cycle.
        if (burst_last && (!addr_last || read_phase)) begin
          cur_q        <= setup_addr;
          burst_addr_q <= setup_addr[AMM_ADDR_W-1:0];
          burst_n_q    <= setup_n;
          beats_left_q <= setup_n;
        end
      end

      if (rd_beat) begin
        cur_q        <= cur_q + 32'd1;
        beats_left_q <= beats_left_q - AMM_BURST_W'(1);
        if (burst_last && !addr_last) begin
          burst_addr_q <= setup_addr[AMM_ADDR_W-1:0];
          burst_n_q    <= setup_n;
          beats_left_q <= setup_n;
        end
        if (mem_readdata_i != exp_data) begin
          if (err_count_q != '1) begin
            err_count_q <= err_count_q + 32'd1;
          end
          if (!error_q) begin
            first_err_addr_q <= cur_q;
          end
          error_q <= 1'b1;
        end
      end

      if ((state_d == StDone) && (busy || start_req)) begin
        done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (sys_address_i)
      4'd0:    csr_rdata = {31'd0, busy};
      4'd1:    csr_rdata = {30'd0, mode_q};
      4'd2:    csr_rdata = start_addr_q;
      4'd3:    csr_rdata = end_addr_q;
      4'd4:    csr_rdata = burst_len_q;
      4'd5:    csr_rdata = pattern_q;
      4'd8:    csr_rdata = {28'd0, cfg_err_q, error_q, done_q, busy};
      4'd9:    csr_rdata = err_count_q;
      4'd10:   csr_rdata = first_err_addr_q;
      4'd11:   csr_rdata = cycles_q;
      default: csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      rdvalid_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rdvalid_q <= sys_read_i;
      rdata_q   <= sys_read_i ? csr_rdata : '0;
    end
  end

  assign sys_readdatavalid_o = rdvalid_q;
  assign sys_readdata_o      = rdata_q;

endmodule

// File: tb/tb_amm_mem_checker.sv
// Directed bench for amm_mem_checker with a small Avalon-MM memory model that
// can stall, gap read beats and corrupt one word on read-back.
module tb_amm_mem_checker;

  logic         clk, rst;
  logic         sys_read, sys_write;
  logic [3:0]   sys_address;
  logic [31:0]  sys_writedata, sys_readdata;
  logic         sys_readdatavalid;
  logic         mem_waitrequest, mem_readdatavalid;
  logic [127:0] mem_readdata, mem_writedata;
  logic [27:0]  mem_address;
  logic         mem_read, mem_write;
  logic [10:0]  mem_burstcount;
  logic [15:0]  mem_byteenable;

  amm_mem_checker dut (
    .clk_sys_i          (clk),
    .rst_i              (rst),
    .sys_read_i         (sys_read),
    .sys_write_i        (sys_write),
    .sys_address_i      (sys_address),
    .sys_writedata_i    (sys_writedata),
    .sys_readdatavalid_o(sys_readdatavalid),
    .sys_readdata_o     (sys_readdata),
    .mem_waitrequest_i  (mem_waitrequest),
    .mem_readdatavalid_i(mem_readdatavalid),
    .mem_readdata_i     (mem_readdata),
    .mem_address_o      (mem_address),
    .mem_read_o         (mem_read),
    .mem_write_o        (mem_write),
    .mem_writedata_o    (mem_writedata),
    .mem_burstcount_o   (mem_burstcount),
    .mem_byteenable_o   (mem_byteenable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model state; written only by the model process.
  logic [127:0] mem [256];
  logic [31:0]  wr_log_addr[$];
  int           wr_log_cnt[$];
  logic [31:0]  rd_log_addr[$];
  int           rd_log_cnt[$];
  int           strobes = 0;
  int           proto_viol = 0;
  bit           rand_mode = 0;
  bit           corrupt_en = 0;
  logic [31:0]  corrupt_addr = 32'h13;

  initial begin
    int          wr_idx, rd_left;
    logic [31:0] rd_addr;
    logic [127:0] d;
    logic        prev_stall, prev_write;
    logic [27:0] prev_addr;
    logic [10:0] prev_cnt;
    logic [127:0] prev_wdata;
    logic [7:0]  ia;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    wr_idx = 0; rd_left = 0; rd_addr = '0; prev_stall = 0;
    prev_write = 0; prev_addr = '0; prev_cnt = '0; prev_wdata = '0;
    mem_waitrequest = 0; mem_readdatavalid = 0; mem_readdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_idx = 0; rd_left = 0; prev_stall = 0;
        mem_waitrequest = 0; mem_readdatavalid = 0; mem_readdata = '0;
      end else begin
        // Return a pending read beat before taking any new command.
        if (rd_left > 0 && (!rand_mode || $urandom_range(0, 1) == 1)) begin
          ia = rd_addr[7:0];
          d = mem[ia];
          if (corrupt_en && rd_addr == corrupt_addr) d = ~d;
          mem_readdatavalid = 1; mem_readdata = d;
          rd_addr++; rd_left--;
        end else begin
          mem_readdatavalid = 0; mem_readdata = '0;
        end
        mem_waitrequest = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
        if (prev_stall && (mem_write != prev_write || mem_address != prev_addr ||
            mem_burstcount != prev_cnt || mem_writedata != prev_wdata)) proto_viol++;
        if (mem_byteenable != (mem_write ? 16'hFFFF : 16'h0000)) proto_viol++;
        prev_stall = mem_waitrequest && (mem_write || mem_read);
        prev_write = mem_write; prev_addr = mem_address;
        prev_cnt = mem_burstcount; prev_wdata = mem_writedata;
        if (mem_write || mem_read) strobes++;
        if (mem_write && !mem_waitrequest) begin
          if (wr_idx == 0) begin
            wr_log_addr.push_back(32'(mem_address));
            wr_log_cnt.push_back(int'(mem_burstcount));
          end
          ia = 8'(32'(mem_address) + wr_idx);
          mem[ia] = mem_writedata;
          wr_idx = (wr_idx + 1 == int'(mem_burstcount)) ? 0 : wr_idx + 1;
        end
        if (mem_read && !mem_waitrequest) begin
          rd_log_addr.push_back(32'(mem_address));
          rd_log_cnt.push_back(int'(mem_burstcount));
          rd_addr = 32'(mem_address);
          rd_left = int'(mem_burstcount);
        end
      end
    end
  end

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    sys_write = 1; sys_address = a; sys_writedata = d;
    @(negedge clk);
    sys_write = 0;
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [31:0] d, output logic v);
    sys_read = 1; sys_address = a;
    @(negedge clk);
    sys_read = 0;
    v = sys_readdatavalid; d = sys_readdata;
  endtask

  task automatic configure(input logic [1:0] mode, input logic [31:0] sa, input logic [31:0] ea,
                           input logic [31:0] bl, input logic [31:0] pat);
    csr_write(4'd1, {30'd0, mode});
    csr_write(4'd2, sa);
    csr_write(4'd3, ea);
    csr_write(4'd4, bl);
    csr_write(4'd5, pat);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    logic        v;
    int          n;
    n = 0;
    do begin
      csr_read(4'd8, s, v);
      n++;
    end while (s[0] && n < 20000);
    check_eq(tag, {31'd0, s[0]}, 32'd0);
  endtask

  task automatic expect_csr(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    csr_read(a, d, v);
    check_eq(tag, d, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int          wb, rb, s0, pv0;
    logic [31:0] d;
    logic        v;
    logic [127:0] w;
    rst = 1; sys_read = 0; sys_write = 0; sys_address = '0; sys_writedata = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);

    expect_csr("rst_status", 4'd8, 32'h0);
    expect_csr("rst_burst_len", 4'd4, 32'h1);
    expect_csr("rst_err_count", 4'd9, 32'h0);
    expect_csr("rst_mode", 4'd1, 32'h0);

    csr_write(4'd2, 32'h100);
    csr_read(4'd2, d, v);
    check_eq("csr_rd_valid", {31'd0, v}, 32'd1);
    check_eq("csr_rd_data", d, 32'h100);
    @(negedge clk);
    check_eq("csr_rd_valid_drop", {31'd0, sys_readdatavalid}, 32'd0);
    expect_csr("csr_unmapped", 4'd7, 32'h0);

    pv0 = proto_viol;

    // Write-then-read over 64 words, ideal memory.
    wb = wr_log_addr.size(); rb = rd_log_addr.size();
    configure(2'd2, 32'h0, 32'h3F, 32'd8, 32'hA5A5A5A5);
    csr_write(4'd0, 32'h1);
    wait_done("t1_done_wait");
    expect_csr("t1_status", 4'd8, 32'h2);
    expect_csr("t1_err_count", 4'd9, 32'h0);
    expect_csr("t1_cycles", 4'd11, 32'd136);
    check_eq("t1_wr_bursts", wr_log_addr.size() - wb, 32'd8);
    check_eq("t1_rd_bursts", rd_log_addr.size() - rb, 32'd8);
    check_eq("t1_last_wr_addr", wr_log_addr[wb + 7], 32'h38);
    check_eq("t1_wr_cnt", wr_log_cnt[wb], 32'd8);
    w = mem[8'h13];
    check_eq("t1_mem13_lane0", w[31:0], 32'hA5A5A5B6);
    check_eq("t1_mem13_lane3", w[127:96], 32'hA5A5A5B6);

    // Same run with word 0x13 corrupted on read-back.
    corrupt_en = 1;
    csr_write(4'd0, 32'h1);
    wait_done("t2_done_wait");
    corrupt_en = 0;
    expect_csr("t2_status", 4'd8, 32'h6);
    expect_csr("t2_err_count", 4'd9, 32'h1);
    expect_csr("t2_first_err", 4'd10, 32'h13);

    // Short range with a partial final burst, write-only.
    wb = wr_log_addr.size(); rb = rd_log_addr.size();
    configure(2'd0, 32'h10, 32'h14, 32'd4, 32'h12345678);
    csr_write(4'd0, 32'h1);
    wait_done("t3_done_wait");
    expect_csr("t3_status", 4'd8, 32'h2);
    expect_csr("t3_cycles", 4'd11, 32'd5);
    check_eq("t3_wr_bursts", wr_log_addr.size() - wb, 32'd2);
    check_eq("t3_rd_bursts", rd_log_addr.size() - rb, 32'd0);
    check_eq("t3_b0_addr", wr_log_addr[wb], 32'h10);
    check_eq("t3_b0_cnt", wr_log_cnt[wb], 32'd4);
    check_eq("t3_b1_addr", wr_log_addr[wb + 1], 32'h14);
    check_eq("t3_b1_cnt", wr_log_cnt[wb + 1], 32'd1);

    // Random stalls and read gaps; mode 3 behaves as write-then-read.
    rb = rd_log_addr.size();
    rand_mode = 1;
    configure(2'd3, 32'h20, 32'h4F, 32'd16, 32'h3C3C0F0F);
    csr_write(4'd0, 32'h1);
    wait_done("t4_done_wait");
    rand_mode = 0;
    expect_csr("t4_status", 4'd8, 32'h2);
    expect_csr("t4_err_count", 4'd9, 32'h0);
    check_eq("t4_rd_bursts", rd_log_addr.size() - rb, 32'd3);
    for (int a = 32'h20; a <= 32'h4F; a++) begin
      w = mem[a];
      check_eq("t4_mem_lane0", w[31:0], 32'h3C3C0F0F ^ 32'(a));
    end
    check_eq("t4_protocol", proto_viol - pv0, 32'd0);

    // Read-only with a pattern that disagrees with every stored word.
    wb = wr_log_addr.size(); rb = rd_log_addr.size();
    configure(2'd1, 32'h20, 32'h27, 32'd3, 32'h0);
    csr_write(4'd0, 32'h1);
    wait_done("t5_done_wait");
    expect_csr("t5_status", 4'd8, 32'h6);
    expect_csr("t5_err_count", 4'd9, 32'd8);
    expect_csr("t5_first_err", 4'd10, 32'h20);
    check_eq("t5_wr_bursts", wr_log_addr.size() - wb, 32'd0);
    check_eq("t5_rd_bursts", rd_log_addr.size() - rb, 32'd3);
    check_eq("t5_last_rd_cnt", rd_log_cnt[rb + 2], 32'd2);

    // BURST_LEN 0 behaves as 1.
    wb = wr_log_addr.size();
    configure(2'd0, 32'h0, 32'h2, 32'd0, 32'h0);
    csr_write(4'd0, 32'h1);
    wait_done("t6_done_wait");
    check_eq("t6_wr_bursts", wr_log_addr.size() - wb, 32'd3);
    check_eq("t6_last_addr", wr_log_addr[wb + 2], 32'h2);
    check_eq("t6_last_cnt", wr_log_cnt[wb + 2], 32'd1);

    // Oversized BURST_LEN clamps to 1024; config write and restart while busy ignored.
    wb = wr_log_addr.size();
    configure(2'd0, 32'h0, 32'd1500, 32'd5000, 32'h0F0F0F0F);
    csr_write(4'd0, 32'h1);
    csr_write(4'd4, 32'd7);
    csr_write(4'd0, 32'h1);
    expect_csr("t7_busy", 4'd0, 32'h1);
    wait_done("t7_done_wait");
    expect_csr("t7_cycles", 4'd11, 32'd1501);
    check_eq("t7_wr_bursts", wr_log_addr.size() - wb, 32'd2);
    check_eq("t7_b0_cnt", wr_log_cnt[wb], 32'd1024);
    check_eq("t7_b1_addr", wr_log_addr[wb + 1], 32'd1024);
    check_eq("t7_b1_cnt", wr_log_cnt[wb + 1], 32'd477);

    // START > END: no memory activity, done + cfg_err right away.
    configure(2'd2, 32'd5, 32'd4, 32'd8, 32'h0);
    s0 = strobes;
    csr_write(4'd0, 32'h1);
    expect_csr("t8_status", 4'd8, 32'hA);
    repeat (3) @(negedge clk);
    check_eq("t8_no_strobes", strobes - s0, 32'd0);

    // Reset in the middle of a write burst.
    configure(2'd0, 32'h0, 32'h3F, 32'd64, 32'h0);
    csr_write(4'd0, 32'h1);
    @(negedge clk);
    check_eq("t9_write_active", {31'd0, mem_write}, 32'd1);
    rst = 1;
    @(negedge clk);
    check_eq("t9_write_dropped", {31'd0, mem_write}, 32'd0);
    check_eq("t9_read_dropped", {31'd0, mem_read}, 32'd0);
    rst = 0;
    @(negedge clk);
    expect_csr("t9_status", 4'd8, 32'h0);
    expect_csr("t9_burst_len", 4'd4, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
